custom_logic_merge: RTL
=======================

// Module: custom_logic_merge
// PURPOSE
//  2-to-1 stream merge: the join counterpart of the fork stage. Two upstream
//  valid/ready streams (A, B) are combined into one downstream stream.
//  Round-robin arbitration decides the order. A registered output stage gives
//  1-cycle latency and full throughput.
//  Sits between two ff_fifo_pow2_depth producers and one downstream FIFO.
// PARAMETERS
//  D_WIDTH  6   data width of every stream, in bits
//  CNT_W    16  width of the per-input beat counters (used only with MERGE_CNT_EN)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        reset: asynchronous, active-high
//  up_data_a     in   D_WIDTH  input A data
//  up_valid_a    in   1        input A valid
//  up_ready_a    out  1        input A ready
//  up_data_b     in   D_WIDTH  input B data
//  up_valid_b    in   1        input B valid
//  up_ready_b    out  1        input B ready
//  down_data     out  D_WIDTH  merged data, registered
//  down_src      out  1        source of the beat in down_data: 0=A, 1=B; registered
//  down_valid    out  1        merged valid, registered
//  down_ready    in   1        downstream ready
//  cnt_a         out  CNT_W    beats accepted from A (only with MERGE_CNT_EN)
//  cnt_b         out  CNT_W    beats accepted from B (only with MERGE_CNT_EN)
// BEHAVIOUR
//  - Reset values: down_valid=0, down_data=0, down_src=0, prio=A, cnt_a=cnt_b=0.
//    Reset asserted mid-transfer discards the held beat.
//  - load = ~down_valid | down_ready. This is combinational; there is no
//    bubble when the output drains and refills in the same cycle.
//  - Grant, combinational:
//    - only A valid -> A; only B valid -> B;
//    - both valid -> the side named by prio; neither valid -> no grant.
//  - up_ready_x = load & grant_x, so at most one up_ready is high per cycle.
//    ready may depend on valid; upstream must not make valid depend on ready.
//  - Transfer on a side = up_valid_x & up_ready_x.
//    On a transfer, next cycle: down_data<=up_data_x, down_src<=x, down_valid<=1.
//  - If load holds and there is no transfer: down_valid<=0, down_data holds.
//    If ~load: all output registers hold; data must stay stable while stalled.
//  - prio update: after each transfer, prio <= the non-winning side. No transfer -> hold.
//    Result: sustained dual traffic strictly alternates A,B,A,B...
//  - Latency: 1 cycle from the upstream transfer to down_valid.
//    Throughput: 1 beat/cycle when down_ready is held at 1.
//  - A valid input that loses arbitration keeps its valid asserted and data
//    stable (upstream rule).
//    Starvation bound: served within 2 output slots.
// CONFIGURATION
//  - MERGE_CNT_EN defined: cnt_a/cnt_b ports exist.
//    Each counter increments by 1 on its side's transfer and saturates at
//    2**CNT_W-1 (no wrap). Cleared only by rst.
//  - MERGE_CNT_EN undefined: cnt_a, cnt_b and the counter logic are absent.
//    All other behaviour is identical.
// STRUCTURE
//  - Package merge_pkg:
//    - typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_e, used for prio and down_src;
//    - localparam CNT_W_DEF=16.
//  - Sub-module merge_arb_rr2:
//    - inputs: req_a, req_b, en (=load), clk, rst;
//    - outputs: gnt_a, gnt_b;
//    - owns the prio register.
//    The top level holds the output register and the counters.
// TESTING
//  - Reset: assert rst asynchronously mid-cycle while down_valid=1.
//    -> down_valid=0, down_data=0, prio=A immediately; no spurious beat after
//    release.
//  - Single source, down_ready=1: A sends 0x01..0x05 back-to-back.
//    -> down_data 0x01..0x05 on consecutive cycles, 1-cycle latency, down_src=0.
//  - Contention, down_ready=1: A holds 0x0A, B holds 0x2B, both valid for
//    4 cycles, new data each beat.
//    -> order A,B,A,B, down_src 0,1,0,1, no idle cycle.
//  - Backpressure: down_ready=0 for 3 cycles with down_valid=1 (data 0x15).
//    -> up_ready_a=up_ready_b=0; down_data stays 0x15; after release the
//    next beat follows with no gap.
//  - Last-winner fairness: B wins alone (0x30); A and B then request together.
//    -> A is served first, then B.
//  - MERGE_CNT_EN with CNT_W=2: 5 A beats and 2 B beats.
//    -> cnt_a=3 (saturated), cnt_b=2. Without the macro the bench elaborates
//    with no cnt ports.

Source files
------------

// File: rtl/merge_pkg.sv
// merge_pkg: shared types for the 2-to-1 stream merge (source/priority encoding, default counter width)
package merge_pkg;
  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/merge_arb_rr2.sv
// merge_arb_rr2: two-requester round-robin arbiter; owns the priority register
//   clk, rst        clock, asynchronous active-high reset
//   req_a, req_b    requests (upstream valids)
//   en              grant is consumed this cycle (output stage can load)
//   gnt_a, gnt_b    one-hot-or-zero grant
module merge_arb_rr2
  import merge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);
  src_e prio_q, prio_d;
  // prio names the side that wins a tie; after a consumed grant it moves to the loser
  always_comb begin
    gnt_a  = req_a & (~req_b | (prio_q == SRC_A));
    gnt_b  = req_b & (~req_a | (prio_q == SRC_B));
    prio_d = (en & gnt_a) ? SRC_B : (en & gnt_b) ? SRC_A : prio_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) prio_q <= SRC_A;
    else     prio_q <= prio_d;
endmodule

// File: rtl/custom_logic_merge.sv
// custom_logic_merge: 2-to-1 valid/ready stream merge with round-robin arbitration and a registered output
//   clk, rst                          clock, asynchronous active-high reset
//   up_data_x/up_valid_x/up_ready_x   upstream streams A and B
//   down_data/down_src/down_valid     registered merged beat and its source (0=A, 1=B)
//   down_ready                        downstream ready
//   cnt_a, cnt_b                      saturating accepted-beat counters, present only with MERGE_CNT_EN
module custom_logic_merge
  import merge_pkg::*;
#(
  parameter int D_WIDTH = 6
`ifdef MERGE_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data_a,
  input  logic               up_valid_a,
  output logic               up_ready_a,
  input  logic [D_WIDTH-1:0] up_data_b,
  input  logic               up_valid_b,
  output logic               up_ready_b,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_src,
  output logic               down_valid,
  input  logic               down_ready
`ifdef MERGE_CNT_EN
  , output logic [CNT_W-1:0] cnt_a
  , output logic [CNT_W-1:0] cnt_b
`endif
);
  logic load, gnt_a, gnt_b, xfer_a, xfer_b;
  logic valid_q, valid_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  src_e src_q, src_d;
  // output register empty or draining this cycle: refill without a bubble
  assign load       = ~valid_q | down_ready;
  assign up_ready_a = load & gnt_a;
  assign up_ready_b = load & gnt_b;
  assign xfer_a     = up_valid_a & up_ready_a;
  assign xfer_b     = up_valid_b & up_ready_b;
  merge_arb_rr2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (up_valid_a),
    .req_b (up_valid_b),
    .en    (load),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );
  always_comb begin
    valid_d = load ? (xfer_a | xfer_b) : valid_q;
    data_d  = xfer_a ? up_data_a : xfer_b ? up_data_b : data_q;
    src_d   = xfer_a ? SRC_A : xfer_b ? SRC_B : src_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= SRC_A;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  assign down_valid = valid_q;
  assign down_data  = data_q;
  assign down_src   = src_q;
`ifdef MERGE_CNT_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  always_comb begin
    cnt_a_d = (xfer_a && cnt_a_q != '1) ? cnt_a_q + CNT_W'(1) : cnt_a_q;
    cnt_b_d = (xfer_b && cnt_b_q != '1) ? cnt_b_q + CNT_W'(1) : cnt_b_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif
endmodule
